// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM encoding, default baud divider and frame constants for the UART receiver
package uart_pkg;
  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    START_BIT = 2'b01,
    RECEIVING = 2'b11,
    STOP_BIT  = 2'b10
  } state_t;
  localparam int unsigned N_DEFAULT = 5;
  localparam logic [4:0] FULL_DEFAULT = 5'd29;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchroniser for Rx plus a previous-value flop for falling-edge detection
// Ports: Clk, nReset (async active-low), rx (async line in), rx_s (synchronised line), fall_edge (rx_s went 1->0)
module uart_rx_sync (
  input  logic Clk,
  input  logic nReset,
  input  logic rx,
  output logic rx_s,
  output logic fall_edge
);
  logic meta_q, sync_q, prev_q;
  // All flops reset to the idle-high line level so reset never looks like a start bit.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end
  assign rx_s = sync_q;
  assign fall_edge = prev_q & ~sync_q;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 LSB-first UART receiver with mid-bit sampling, held Valid/Ack handshake, framing and overrun pulses
// Ports: Clk, nReset (async active-low), Rx (serial in), Data/Valid (received byte, held until Ack),
//        Ack (clears Valid), Busy (frame in progress), FrameError/Overrun (one-cycle pulses)
module uart_receiver
  import uart_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter logic [N-1:0] Full = N'(FULL_DEFAULT)
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       Rx,
  output logic [7:0] Data,
  output logic       Valid,
  input  logic       Ack,
  output logic       Busy,
  output logic       FrameError,
  output logic       Overrun
);
  localparam logic [N-1:0] HALF = Full >> 1;
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);
  logic rx_s, fall_edge;
  state_t state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic valid_q, valid_d, busy_q, busy_d, fe_q, fe_d, ov_q, ov_d;
  uart_rx_sync u_sync (
    .Clk(Clk),
    .nReset(nReset),
    .rx(Rx),
    .rx_s(rx_s),
    .fall_edge(fall_edge)
  );
  always_comb begin
    state_d = state_q;
    count_d = (count_q != '0) ? count_q - 1'b1 : count_q;
    bit_cnt_d = bit_cnt_q;
    shift_d = shift_q;
    data_d = data_q;
    valid_d = valid_q & ~Ack;
    busy_d = busy_q;
    fe_d = 1'b0;
    ov_d = 1'b0;
    unique case (state_q)
      IDLE: if (fall_edge) begin
        count_d = HALF;
        busy_d = 1'b1;
        state_d = START_BIT;
      end
      START_BIT: if (count_q == '0) begin
        if (!rx_s) begin
          count_d = Full;
          bit_cnt_d = LAST_BIT;
          state_d = RECEIVING;
        end else begin
          busy_d = 1'b0;
          state_d = IDLE;
        end
      end
      RECEIVING: if (count_q == '0) begin
        shift_d = {rx_s, shift_q[7:1]};
        count_d = Full;
        if (bit_cnt_q == '0) state_d = STOP_BIT;
        else bit_cnt_d = bit_cnt_q - 3'd1;
      end
      STOP_BIT: if (count_q == '0) begin
        busy_d = 1'b0;
        state_d = IDLE;
        // A new byte always wins over a coincident Ack; Ack only suppresses the overrun.
        if (rx_s) begin
          data_d = shift_q;
          valid_d = 1'b1;
          ov_d = valid_q & ~Ack;
        end else begin
          fe_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      count_q <= '0;
      bit_cnt_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      fe_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q <= shift_d;
      data_q <= data_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      fe_q <= fe_d;
      ov_q <= ov_d;
    end
  end
  assign Data = data_q;
  assign Valid = valid_q;
  assign Busy = busy_q;
  assign FrameError = fe_q;
  assign Overrun = ov_q;
endmodule
